// File: rtl/fetch_icache.sv
// fetch_icache: instruction-fetch stage with a direct-mapped,
// one-word-per-line instruction cache in front of memctrl.
//
// Hits return in one clock; misses issue a word read on the memctrl
// IF port, refill the line on done and forward the word to decode.
// Jump redirects and decode stalls are handled here as well.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global ready; low freezes every register
//   stall_i         decode cannot accept; outputs are held
//   jump_i          redirect pulse from EX, target on jump_addr_i
//   flush_cache_i   invalidate every line (fence.i)
//   mem_req_i       MEM stage owns memctrl this cycle
//   if_re_o         memctrl IF read enable
//   if_addr_o       memctrl IF byte address
//   mc_busy_i       memctrl busy
//   mc_done_i       memctrl done (shared by IF and MEM)
//   mc_data_i       memctrl read data
//   pc_o            pc of inst_o
//   inst_o          fetched instruction
//   inst_valid_o    pc_o/inst_o valid for decode

module fetch_icache #(
    parameter int                ADDR_W     = 32,
    parameter int                INDEX_BITS = 6,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              flush_cache_i,
    input  logic              mem_req_i,
    output logic              if_re_o,
    output logic [ADDR_W-1:0] if_addr_o,
    input  logic              mc_busy_i,
    input  logic              mc_done_i,
    input  logic [31:0]       mc_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_RUN,
        S_MISS_REQ,
        S_MISS_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] pco_q, pco_d;
    logic [31:0]       inst_q, inst_d;
    logic              vld_q, vld_d;
    logic              pend_q, pend_d;
    logic [LINES-1:0]  valid_q, valid_d;

    // Tag/data arrays carry no reset; the valid vector gates them.
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [ADDR_W-1:0]     pc_inc;
    logic                  hit;
    logic                  accept;
    logic                  refill;

    assign idx    = pc_q[INDEX_BITS+1:2];
    assign tag    = pc_q[ADDR_W-1:INDEX_BITS+2];
    assign pc_inc = pc_q + ADDR_W'(4);
    assign hit    = valid_q[idx] && (tag_mem[idx] == tag);

    // memctrl latches our request on this edge; MEM has priority.
    assign accept = (state_q == S_MISS_REQ)
                  && !mc_busy_i && !mem_req_i;

    assign if_re_o      = (state_q == S_MISS_REQ);
    assign if_addr_o    = pc_q;
    assign pc_o         = pco_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = vld_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pco_d   = pco_q;
        inst_d  = inst_q;
        vld_d   = vld_q;
        pend_d  = pend_q;
        refill  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (jump_i) begin
                    pc_d  = jump_addr_i;
                    vld_d = 1'b0;
                end else if (!stall_i) begin
                    if (hit) begin
                        inst_d = data_mem[idx];
                        pco_d  = pc_q;
                        vld_d  = 1'b1;
                        pc_d   = pc_inc;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = S_MISS_REQ;
                    end
                end
            end

            S_MISS_REQ: begin
                if (accept) begin
                    state_d = S_MISS_WAIT;
                    // Transaction is committed; remember
                    // the redirect for when it completes.
                    if (jump_i) begin
                        pend_d = 1'b1;
                        tgt_d  = jump_addr_i;
                    end
                end else if (jump_i) begin
                    pc_d    = jump_addr_i;
                    state_d = S_RUN;
                end
            end

            S_MISS_WAIT: begin
                if (jump_i) begin
                    pend_d = 1'b1;
                    tgt_d  = jump_addr_i;
                end
                // Only our read can complete here: MEM was
                // locked out when the request was accepted.
                if (mc_done_i) begin
                    refill  = 1'b1;
                    state_d = S_RUN;
                    if (jump_i) begin
                        pc_d   = jump_addr_i;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else if (!stall_i) begin
                        inst_d = mc_data_i;
                        pco_d  = pc_q;
                        vld_d  = 1'b1;
                        pc_d   = pc_inc;
                    end
                    // Stalled refill: the next unstalled
                    // cycle in RUN hits the new line.
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // A refill on a flush edge lands invalid.
    always_comb begin
        valid_d = valid_q;
        if (refill) begin
            valid_d[idx] = 1'b1;
        end
        if (flush_cache_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            pco_q   <= '0;
            inst_q  <= 32'h0;
            vld_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pco_q   <= pco_d;
            inst_q  <= inst_d;
            vld_q   <= vld_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && refill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mc_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_icache.sv
// tb_fetch_icache: directed and random checks of fetch_icache
// against a memctrl model and a program-order/cache reference model.

module tb_fetch_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy, stall_i, jump_i, flush_cache_i, mem_req_i;
    logic [31:0] jump_addr_i;
    logic        if_re_o;
    logic [31:0] if_addr_o;
    logic        mc_busy_i, mc_done_i;
    logic [31:0] mc_data_i;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    fetch_icache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .flush_cache_i(flush_cache_i),
        .mem_req_i    (mem_req_i),
        .if_re_o      (if_re_o),
        .if_addr_o    (if_addr_o),
        .mc_busy_i    (mc_busy_i),
        .mc_done_i    (mc_done_i),
        .mc_data_i    (mc_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    int errors = 0;
    int checks = 0;

    // memctrl model: cycles left, owner, address, latency
    int          mc_cnt;
    bit          mc_if;
    logic [31:0] mc_addr;
    int          lat;

    // reference: next pc in program order, cache contents
    logic [31:0] exp_pc;
    bit          mvalid [64];
    logic [31:0] maddr [64];
    bit          if_out, redir;
    int          deliveries;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'd0) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Word address a lives in slot (a/4) mod 64 when cached.
    function automatic bit mhit(input logic [31:0] a);
        int i;
        i = int'(a[7:2]);
        return mvalid[i] && (maddr[i] == {a[31:2], 2'b00});
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        exp_pc     = 32'h0;
        mc_cnt     = 0;
        mc_if      = 1'b0;
        if_out     = 1'b0;
        redir      = 1'b0;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        stall_i = 0; jump_i = 0; flush_cache_i = 0;
        mem_req_i = 0; jump_addr_i = 0;
        mc_busy_i = 0; mc_done_i = 0; mc_data_i = 0;
        #1;
        chk("rst_vld", inst_valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_re", if_re_o, 0);
        chk("rst_addr", if_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_models();
    endtask

    // One clock: called at negedge with inputs already set.
    task automatic cyc();
        logic        pre_vld, pre_re;
        logic [31:0] pre_pc, pre_inst, pre_addr;
        bit          acc_if, acc_mem, done_if;
        mc_busy_i = (mc_cnt > 0);
        mc_done_i = (mc_cnt == 1);
        mc_data_i = (mc_cnt == 1 && mc_if) ?
                    mem_word(mc_addr) : $urandom;
        pre_vld  = inst_valid_o;
        pre_re   = if_re_o;
        pre_pc   = pc_o;
        pre_inst = inst_o;
        pre_addr = if_addr_o;
        done_if  = rdy && mc_cnt == 1 && mc_if;
        acc_mem  = rdy && mc_cnt == 0 && mem_req_i;
        acc_if   = rdy && mc_cnt == 0 && !mem_req_i && pre_re;
        @(posedge clk);
        #1;
        if (!rdy) begin
            chk("frz_vld", inst_valid_o, pre_vld);
            chk("frz_pc", pc_o, pre_pc);
            chk("frz_inst", inst_o, pre_inst);
            chk("frz_re", if_re_o, pre_re);
            chk("frz_addr", if_addr_o, pre_addr);
        end else begin
            if (pre_re)
                chk("accept", if_re_o, !acc_if && !jump_i);
            if (jump_i) begin
                chk("jump_kill", inst_valid_o, 0);
            end else if (stall_i) begin
                chk("hold_vld", inst_valid_o, pre_vld);
                chk("hold_pc", pc_o, pre_pc);
                chk("hold_inst", inst_o, pre_inst);
            end else if (inst_valid_o) begin
                deliveries++;
                chk("deliv_pc", pc_o, exp_pc);
                chk("deliv_inst", inst_o, mem_word(exp_pc));
                chk("deliv_src", done_if || mhit(exp_pc), 1);
                exp_pc = exp_pc + 32'd4;
            end
            if (done_if && !redir && !stall_i && !jump_i)
                chk("refill_out", inst_valid_o, 1);
            if (jump_i) exp_pc = jump_addr_i;
            if (done_if && !flush_cache_i) begin
                mvalid[int'(mc_addr[7:2])] = 1'b1;
                maddr[int'(mc_addr[7:2])]  = {mc_addr[31:2], 2'b00};
            end
            if (flush_cache_i)
                for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
            if (acc_if) begin
                if_out = 1'b1;
                redir  = jump_i;
            end else if (if_out && jump_i) begin
                redir = 1'b1;
            end
            if (done_if) if_out = 1'b0;
            if (mc_cnt > 0) begin
                mc_cnt--;
            end else if (acc_mem) begin
                mc_cnt = lat;
                mc_if  = 1'b0;
            end else if (acc_if) begin
                mc_cnt  = lat;
                mc_if   = 1'b1;
                mc_addr = pre_addr;
            end
            if (if_re_o) begin
                chk("req_addr", if_addr_o, exp_pc);
                chk("req_miss", mhit(exp_pc), 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_deliv(input logic [31:0] a,
                                   input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!got) begin
                cyc();
                if (inst_valid_o && pc_o == a) got = 1'b1;
            end
        end
        chk(tag, got, 1);
    endtask

    task automatic jump_to(input logic [31:0] a);
        jump_i      = 1'b1;
        jump_addr_i = a;
        cyc();
        jump_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)
            return {22'd0, 8'($urandom_range(0, 95)), 2'b00};
        if (r < 9)
            return 32'hFFFFFFE0 + 32'($urandom_range(0, 7)) * 4;
        return {$urandom, 2'b00} & 32'hFFFFFFFC;
    endfunction

    initial begin
        bit got;
        lat = 3;
        deliveries = 0;
        @(negedge clk);
        do_reset();

        // cold start at 0
        cyc();
        chk("t1_re", if_re_o, 1);
        chk("t1_addr", if_addr_o, 0);
        run_until_deliv(32'h0, "t1_deliv");
        chk("t1_inst", inst_o, 32'h00500093);
        chk("t1_pc", pc_o, 0);

        // three-instruction loop, second pass from cache
        run_until_deliv(32'h8, "t2_first");
        jump_to(32'h0);
        chk("t2_kill", inst_valid_o, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t2_vld", inst_valid_o, 1);
            chk("t2_pc", pc_o, 32'(k * 4));
            chk("t2_re", if_re_o, 0);
        end

        // MEM holds memctrl while we wait to issue
        jump_to(32'h200);
        cyc();
        chk("t3_req", if_re_o, 1);
        mem_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3_hold", if_re_o, 1);
        end
        mem_req_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++)
            if (!got) begin
                cyc();
                if (!if_re_o) got = 1'b1;
            end
        chk("t3_acc", got, 1);
        run_until_deliv(32'h200, "t3_deliv");

        // redirect while the 0x10 refill is in flight
        lat = 4;
        jump_to(32'h10);
        cyc();
        chk("t4_req", if_re_o, 1);
        cyc();
        chk("t4_wait", if_re_o, 0);
        jump_to(32'h40);
        run_until_deliv(32'h40, "t4_deliv");
        jump_to(32'h10);
        cyc();
        chk("t4_hit", inst_valid_o, 1);
        chk("t4_hitpc", pc_o, 32'h10);
        chk("t4_re", if_re_o, 0);

        // 0x100 aliases 0x0 and evicts it
        lat = 2;
        jump_to(32'h100);
        run_until_deliv(32'h100, "t5_deliv");
        jump_to(32'h0);
        cyc();
        chk("t5_re", if_re_o, 1);
        chk("t5_addr", if_addr_o, 0);
        run_until_deliv(32'h0, "t5_back");

        // flush after a warm loop, then freeze mid-miss
        run_until_deliv(32'h8, "t6_warm");
        flush_cache_i = 1'b1;
        jump_to(32'h0);
        flush_cache_i = 1'b0;
        cyc();
        chk("t6_re", if_re_o, 1);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_frz", if_re_o, 1);
            chk("t6_fpc", if_addr_o, 0);
        end
        rdy = 1'b1;
        run_until_deliv(32'h0, "t6_deliv");

        // random traffic with one reset in the middle
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            rdy           = ($urandom_range(0, 9) != 0);
            stall_i       = ($urandom_range(0, 3) == 0);
            jump_i        = ($urandom_range(0, 19) == 0);
            jump_addr_i   = pick_target();
            flush_cache_i = ($urandom_range(0, 49) == 0);
            mem_req_i     = ($urandom_range(0, 6) == 0);
            lat           = $urandom_range(1, 4);
            cyc();
        end
        chk("liveness", deliveries > 200, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
